wave_mode_ctrl: RTL and testbench

//   Parametrised waveform-mode selector for the synth voice path. Converts raw

---
 rtl/wave_mode_ctrl.sv | 98 +++++++++
 tb/tb_wave_mode_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_mode_ctrl.sv
// Waveform-mode selector: synchronises and debounces next/prev buttons, turns
// debounced rising edges into bounded wrap-around mode steps, and accepts direct loads.
module wave_mode_ctrl #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_MODE      = 0,
    localparam int MODE_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              key_next,
    input  logic              key_prev,
    input  logic              load_en,
    input  logic [MODE_W-1:0] load_mode,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MODE_W-1:0] MAX_MODE   = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] RST_MODE   = MODE_W'(RESET_MODE);
    localparam logic [MODE_W:0]   NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);

    // Bit 0 is the next key, bit 1 the prev key throughout.
    logic [1:0]       key_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       stable_q, stable_d, stable_prev_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press;
    logic             load_ok;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic             changed_q, changed_d;

    assign key_raw = {key_prev, key_next};
    assign press   = stable_q & ~stable_prev_q;
    assign load_ok = ({1'b0, load_mode} < NUM_MODES_W) && (load_mode != mode_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        stable_d = stable_q;
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != stable_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    stable_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // A load strobe owns the cycle even when it is rejected, swallowing any press.
    always_comb begin
        mode_d    = mode_q;
        changed_d = 1'b0;
        if (load_en) begin
            if (load_ok) begin
                mode_d    = load_mode;
                changed_d = 1'b1;
            end
        end else if (press == 2'b01) begin
            mode_d    = (mode_q == MAX_MODE) ? '0 : mode_q + MODE_W'(1);
            changed_d = 1'b1;
        end else if (press == 2'b10) begin
            mode_d    = (mode_q == '0) ? MAX_MODE : mode_q - MODE_W'(1);
            changed_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            // NOTE: the counter array is tiny, so it is reset with the rest to make mid-debounce reset clean.
            for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
            mode_q        <= RST_MODE;
            changed_q     <= 1'b0;
        end else begin
            sync1_q       <= key_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
            mode_q        <= mode_d;
            changed_q     <= changed_d;
        end
    end

    assign mode         = mode_q;
    assign mode_changed = changed_q;

endmodule

// File: tb/tb_wave_mode_ctrl.sv
// Directed self-checking bench for wave_mode_ctrl: a 4-mode and a 5-mode instance.
module tb_wave_mode_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       kn4 = 1'b0, kp4 = 1'b0, le4 = 1'b0;
    logic [1:0] lm4 = '0;
    logic [1:0] mode4;
    logic       chg4;
    logic       kn5 = 1'b0, kp5 = 1'b0, le5 = 1'b0;
    logic [2:0] lm5 = '0;
    logic [2:0] mode5;
    logic       chg5;

    int tests = 0;
    int fails = 0;
    int p4, p5;

    always #5 clk = ~clk;

    wave_mode_ctrl #(.NUM_MODES(4), .DEBOUNCE_CYCLES(4), .RESET_MODE(0)) dut4 (
        .clk(clk), .n_rst(n_rst), .key_next(kn4), .key_prev(kp4),
        .load_en(le4), .load_mode(lm4), .mode(mode4), .mode_changed(chg4)
    );

    wave_mode_ctrl #(.NUM_MODES(5), .DEBOUNCE_CYCLES(4), .RESET_MODE(0)) dut5 (
        .clk(clk), .n_rst(n_rst), .key_next(kn5), .key_prev(kp5),
        .load_en(le5), .load_mode(lm5), .mode(mode5), .mode_changed(chg5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles and counts mode_changed pulses on both instances.
    task automatic run(input int n);
        p4 = 0;
        p5 = 0;
        repeat (n) begin
            tick();
            p4 += int'(chg4);
            p5 += int'(chg5);
        end
    endtask

    // Press one key on the 4-mode DUT; step must land exactly at edge 7.
    task automatic press4(input bit nxt, input logic [1:0] from, input logic [1:0] to,
                          input int hold, input string tag);
        if (nxt) kn4 = 1'b1; else kp4 = 1'b1;
        repeat (6) tick();
        check({tag, "_edge6_mode"}, 32'(mode4), 32'(from));
        check({tag, "_edge6_chg"}, 32'(chg4), 32'd0);
        tick();
        check({tag, "_edge7_mode"}, 32'(mode4), 32'(to));
        check({tag, "_edge7_chg"}, 32'(chg4), 32'd1);
        run(hold);
        kn4 = 1'b0;
        kp4 = 1'b0;
        run(8);
        check({tag, "_after_mode"}, 32'(mode4), 32'(to));
    endtask

    initial begin
        // Reset state while n_rst is held low
        repeat (2) tick();
        check("rst_mode4", 32'(mode4), 32'd0);
        check("rst_chg4", 32'(chg4), 32'd0);
        check("rst_mode5", 32'(mode5), 32'd0);
        n_rst = 1'b1;
        run(3);
        check("idle_pulses", 32'(p4), 32'd0);

        // Four next presses, the first held for 20 cycles
        kn4 = 1'b1;
        repeat (6) tick();
        check("n1_edge6_mode", 32'(mode4), 32'd0);
        tick();
        check("n1_edge7_mode", 32'(mode4), 32'd1);
        check("n1_edge7_chg", 32'(chg4), 32'd1);
        run(20);
        check("n1_held20_pulses", 32'(p4), 32'd0);
        check("n1_held20_mode", 32'(mode4), 32'd1);
        kn4 = 1'b0;
        run(8);
        check("n1_release_pulses", 32'(p4), 32'd0);
        press4(1'b1, 2'd1, 2'd2, 3, "n2");
        press4(1'b1, 2'd2, 2'd3, 3, "n3");
        press4(1'b1, 2'd3, 2'd0, 3, "n4_wrap");

        // Prev from 0 wraps to 3
        press4(1'b0, 2'd0, 2'd3, 3, "p_wrap");

        // 3-cycle glitch on next is rejected
        kn4 = 1'b1;
        repeat (3) tick();
        kn4 = 1'b0;
        run(12);
        check("glitch_pulses", 32'(p4), 32'd0);
        check("glitch_mode", 32'(mode4), 32'd3);

        // Simultaneous next and prev cancel
        kn4 = 1'b1;
        kp4 = 1'b1;
        run(12);
        check("both_pulses", 32'(p4), 32'd0);
        check("both_mode", 32'(mode4), 32'd3);
        kn4 = 1'b0;
        kp4 = 1'b0;
        run(8);

        // Direct load
        le4 = 1'b1;
        lm4 = 2'd2;
        tick();
        check("load2_mode", 32'(mode4), 32'd2);
        check("load2_chg", 32'(chg4), 32'd1);
        tick();
        check("load_same_mode", 32'(mode4), 32'd2);
        check("load_same_chg", 32'(chg4), 32'd0);
        le4 = 1'b0;

        // Rejected load in the press cycle discards the press
        kp4 = 1'b1;
        repeat (6) tick();
        le4 = 1'b1;
        tick();
        check("collide_mode", 32'(mode4), 32'd2);
        check("collide_chg", 32'(chg4), 32'd0);
        le4 = 1'b0;
        run(10);
        check("collide_later_pulses", 32'(p4), 32'd0);
        check("collide_later_mode", 32'(mode4), 32'd2);
        kp4 = 1'b0;
        run(8);

        // 5-mode instance: out-of-range load, load 4, next wraps to 0
        le5 = 1'b1;
        lm5 = 3'd6;
        tick();
        check("m5_load6_mode", 32'(mode5), 32'd0);
        check("m5_load6_chg", 32'(chg5), 32'd0);
        lm5 = 3'd4;
        tick();
        check("m5_load4_mode", 32'(mode5), 32'd4);
        check("m5_load4_chg", 32'(chg5), 32'd1);
        le5 = 1'b0;
        kn5 = 1'b1;
        repeat (6) tick();
        check("m5_edge6_mode", 32'(mode5), 32'd4);
        tick();
        check("m5_wrap_mode", 32'(mode5), 32'd0);
        check("m5_wrap_chg", 32'(chg5), 32'd1);
        kn5 = 1'b0;
        run(8);
        check("m5_release_pulses", 32'(p5), 32'd0);

        // Asynchronous reset mid-cycle, during a change pulse
        kn4 = 1'b1;
        repeat (7) tick();
        check("pre_rst_mode", 32'(mode4), 32'd3);
        check("pre_rst_chg", 32'(chg4), 32'd1);
        #3 n_rst = 1'b0;
        #1;
        check("async_rst_mode", 32'(mode4), 32'd0);
        check("async_rst_chg", 32'(chg4), 32'd0);
        repeat (2) tick();

        // Key held through reset release yields one press after normal latency
        n_rst = 1'b1;
        repeat (6) tick();
        check("held_rst_edge6_mode", 32'(mode4), 32'd0);
        check("held_rst_edge6_chg", 32'(chg4), 32'd0);
        tick();
        check("held_rst_edge7_mode", 32'(mode4), 32'd1);
        check("held_rst_edge7_chg", 32'(chg4), 32'd1);
        run(10);
        check("held_rst_pulses", 32'(p4), 32'd0);
        kn4 = 1'b0;
        run(8);

        // Reset at debounce count 2, key still held afterwards
        kn4 = 1'b1;
        repeat (4) tick();
        #2 n_rst = 1'b0;
        tick();
        check("mid_deb_rst_mode", 32'(mode4), 32'd0);
        n_rst = 1'b1;
        repeat (6) tick();
        check("mid_deb_edge6_mode", 32'(mode4), 32'd0);
        check("mid_deb_edge6_chg", 32'(chg4), 32'd0);
        tick();
        check("mid_deb_edge7_mode", 32'(mode4), 32'd1);
        check("mid_deb_edge7_chg", 32'(chg4), 32'd1);
        kn4 = 1'b0;
        run(10);
        check("final_pulses", 32'(p4), 32'd0);
        check("final_mode", 32'(mode4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
